// File: rtl/pipe_sel_mux_if.sv
// Handshake bundle for pipe_sel_mux: producer offer (data/select/valid),
// consumer acceptance, flush and the registered result with error status.
interface pipe_sel_mux_if #(
  parameter int WIDTH     = 32,
  parameter int NUM_IN    = 4,
  parameter int SEL_W     = 2,
  parameter int ERR_CNT_W = 8
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_sel;
  logic                    sel_err;
  logic [ERR_CNT_W-1:0]    err_cnt;

  modport master (
    output in_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, out_sel, sel_err, err_cnt
  );

  modport slave (
    input  in_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, out_sel, sel_err, err_cnt
  );
endinterface

// File: rtl/pipe_sel_mux.sv
// Registered N-way select stage: picks one of NUM_IN sources into a one-entry
// valid/ready pipeline register, with flush and out-of-range select reporting.
module pipe_sel_mux #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 4,
  parameter int               SEL_W       = 2,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] DEFAULT_VAL = {WIDTH{1'b0}},
  parameter int               ERR_CNT_W   = 8
) (
  input logic           clk,
  input logic           rst_n,
  pipe_sel_mux_if.slave bus
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  state_t               state_r;
  state_t               state_nxt_s;
  logic [WIDTH-1:0]     out_data_r;
  logic [SEL_W-1:0]     out_sel_r;
  logic                 sel_err_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;

  logic [NUM_IN-1:0]    hit_s;
  logic                 in_range_s;
  logic [WIDTH-1:0]     onehot_data_s;
  logic [WIDTH-1:0]     sel_data_s;
  logic                 in_ready_s;
  logic                 accept_s;
  logic                 drain_s;

  // One-hot AND-OR source select; no hit means the select is out of range.
  always_comb begin
    hit_s         = {NUM_IN{1'b0}};
    onehot_data_s = {WIDTH{1'b0}};
    for (int k = 0; k < NUM_IN; k++) begin
      hit_s[k]      = (bus.sel == SEL_W'(k));
      onehot_data_s = onehot_data_s
                    | ({WIDTH{hit_s[k]}} & bus.in_data[k*WIDTH +: WIDTH]);
    end
    in_range_s = |hit_s;
    sel_data_s = in_range_s ? onehot_data_s : DEFAULT_VAL;
  end

  assign in_ready_s = (state_r == ST_EMPTY) || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s && !bus.flush;
  assign drain_s    = (state_r == ST_FULL) && bus.out_ready && !accept_s;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Occupancy next state; flush wins over accept and drain.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (bus.flush) begin
          state_nxt_s = ST_EMPTY;
        end else if (accept_s) begin
          state_nxt_s = ST_FULL;
        end else if (drain_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Payload and status capture; data and select hold on drain and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r <= RESET_VAL;
      out_sel_r  <= {SEL_W{1'b0}};
      sel_err_r  <= 1'b0;
    end else if (bus.flush) begin
      sel_err_r  <= 1'b0;
    end else if (accept_s) begin
      out_data_r <= sel_data_s;
      out_sel_r  <= bus.sel;
      sel_err_r  <= !in_range_s;
    end else if (drain_s) begin
      sel_err_r  <= 1'b0;
    end else begin
      sel_err_r  <= sel_err_r;
    end
  end

  // Saturating count of accepted out-of-range selects; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= {ERR_CNT_W{1'b0}};
    end else if (accept_s && !in_range_s && (err_cnt_r != CNT_MAX)) begin
      err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == ST_FULL);
  assign bus.out_data  = out_data_r;
  assign bus.out_sel   = out_sel_r;
  assign bus.sel_err   = sel_err_r;
  assign bus.err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Self-checking bench for pipe_sel_mux: directed scenarios then random traffic,
// checked against a queue-based model of the one-entry stage.
module tb_pipe_sel_mux;
  localparam int          WIDTH       = 32;
  localparam int          NUM_IN      = 3;
  localparam int          SEL_W       = 2;
  localparam int          ERR_CNT_W   = 8;
  localparam logic [31:0] RESET_VAL   = 32'hDEADBEEF;
  localparam logic [31:0] DEFAULT_VAL = 32'hFFFF0000;
  localparam int          CNT_SAT     = 255;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipe_sel_mux_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W),
                    .ERR_CNT_W(ERR_CNT_W)) bus ();

  pipe_sel_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W),
                 .RESET_VAL(RESET_VAL), .DEFAULT_VAL(DEFAULT_VAL),
                 .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
    logic        err;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_data;
  logic [1:0]  m_sel;
  int          m_cnt;
  logic [31:0] src [NUM_IN];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_in(input int v, input int s, input int fl, input int ordy);
    bus.in_valid  = (v != 0);
    bus.sel       = 2'(s);
    bus.flush     = (fl != 0);
    bus.out_ready = (ordy != 0);
    for (int k = 0; k < NUM_IN; k++) bus.in_data[k*WIDTH +: WIDTH] = src[k];
  endtask

  task automatic model_reset();
    m_q.delete();
    m_data = RESET_VAL;
    m_sel  = 2'd0;
    m_cnt  = 0;
  endtask

  // Apply one clock edge worth of rules to the model from the current inputs.
  task automatic model_step();
    entry_t e;
    bit rdy;
    rdy = (m_q.size() == 0) || bus.out_ready;
    if (bus.flush) begin
      m_q.delete();
    end else begin
      if (bus.out_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (bus.in_valid && rdy) begin
        e.sel = bus.sel;
        e.err = (int'(bus.sel) >= NUM_IN);
        if (e.err) e.data = DEFAULT_VAL;
        else       e.data = src[bus.sel];
        m_q.push_back(e);
        m_data = e.data;
        m_sel  = e.sel;
        if (e.err && m_cnt < CNT_SAT) m_cnt++;
      end
    end
  endtask

  task automatic check_outs(input string tag);
    check_eq({tag, ".valid"}, 64'(bus.out_valid), 64'(m_q.size() != 0));
    check_eq({tag, ".data"},  64'(bus.out_data),  64'(m_data));
    check_eq({tag, ".sel"},   64'(bus.out_sel),   64'(m_sel));
    check_eq({tag, ".err"},   64'(bus.sel_err),   64'((m_q.size() != 0) ? m_q[0].err : 1'b0));
    check_eq({tag, ".cnt"},   64'(bus.err_cnt),   64'(m_cnt));
  endtask

  task automatic check_ready(input string tag);
    check_eq({tag, ".ready"}, 64'(bus.in_ready), 64'((m_q.size() == 0) || bus.out_ready));
  endtask

  task automatic cycle(input string tag);
    #1;
    check_ready(tag);
    model_step();
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  initial begin
    src[0] = 32'h11; src[1] = 32'h22; src[2] = 32'h33;
    set_in(0, 0, 0, 0);
    model_reset();

    // Reset between edges takes effect without a clock edge.
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_outs("reset");
    check_ready("reset");
    check_eq("reset.data_const", 64'(bus.out_data), 64'h0000_0000_DEAD_BEEF);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int s = 0; s < NUM_IN; s++) begin
      set_in(1, s, 0, 1);
      cycle("sweep");
    end

    set_in(1, 3, 0, 1);
    cycle("oor");
    check_eq("oor.data_const", 64'(bus.out_data), 64'h0000_0000_FFFF_0000);

    set_in(0, 0, 0, 1);
    cycle("drain");
    set_in(1, 1, 0, 0);
    cycle("bp_load");
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 0);
      cycle("bp_stall");
    end
    check_eq("bp_hold", 64'(bus.out_data), 64'h22);
    set_in(1, 0, 0, 1);
    cycle("bp_release");
    check_eq("bp_b2b", 64'(bus.out_data), 64'h11);

    set_in(1, 2, 0, 1);
    cycle("fl_load");
    set_in(1, 0, 1, 0);
    cycle("flush");
    check_eq("flush.data_const", 64'(bus.out_data), 64'h33);
    set_in(1, 3, 1, 1);
    cycle("flush_oor");
    check_eq("flush_oor.cnt_const", 64'(bus.err_cnt), 64'd1);

    for (int i = 0; i < 300; i++) begin
      set_in(1, 3, 0, 1);
      cycle("sat");
    end
    check_eq("sat.cnt_const", 64'(bus.err_cnt), 64'd255);

    set_in(1, 1, 0, 1);
    cycle("mr_load");
    set_in(0, 0, 0, 0);
    cycle("mr_hold");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("mid_reset");
    check_ready("mid_reset");
    @(negedge clk) rst_n = 1'b1;
    set_in(1, 2, 0, 0);
    cycle("post_reset");
    check_eq("post_reset.valid_const", 64'(bus.out_valid), 64'd1);

    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < NUM_IN; k++) src[k] = $urandom;
      set_in(($urandom % 4) != 0, $urandom_range(0, 3),
             ($urandom % 8) == 0, ($urandom % 4) != 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
